// File: rtl/binadd_pkg.sv
// Shared definitions for the BinAdd design.
//   state_e              : serial adder controller FSM encoding
//   BINADD_WIDTH_DEFAULT : default operand/result width
package binadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BINADD_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// FA: single-bit full-adder cell.
//   A, B, CIn : addend bits and carry-in
//   S, COut   : sum bit and carry-out
module FA (
    input  logic A,
    input  logic B,
    input  logic CIn,
    output logic S,
    output logic COut
);

    assign S    = A ^ B ^ CIn;
    assign COut = (A & B) | (CIn & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder. One FA cell is reused over WIDTH
// cycles, LSB first, to compute A + B + CIn with a Start/Busy/Done handshake.
//   Clk, Rst       : clock, asynchronous active-high reset
//   Start, A, B, CIn : request and operands (captured when Start is accepted)
//   Busy           : addition in progress
//   Done           : one-cycle pulse when S/COut/Ovf are fresh
//   S, COut, Ovf   : registered sum, carry-out, two's-complement overflow
module serial_add_ctrl
    import binadd_pkg::*;
#(
    parameter int WIDTH = BINADD_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             COut,
    output logic             Ovf
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   shA_q;
    logic [WIDTH-1:0]   shB_q;
    // Only WIDTH-1 sum bits need storing: the final bit goes straight
    // from the FA into S on the last RUN edge.
    logic [WIDTH-2:0]   shS_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   S_q;
    logic               COut_q;
    logic               Ovf_q;

    logic fa_s;
    logic fa_co;

    FA u_fa (
        .A    (shA_q[0]),
        .B    (shB_q[0]),
        .CIn  (carry_q),
        .S    (fa_s),
        .COut (fa_co)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            shA_q   <= '0;
            shB_q   <= '0;
            shS_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            S_q     <= '0;
            COut_q  <= 1'b0;
            Ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // DONE accepts Start exactly like IDLE for back-to-back use.
                    if (Start) begin
                        shA_q   <= A;
                        shB_q   <= B;
                        carry_q <= CIn;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    shA_q   <= shA_q >> 1;
                    shB_q   <= shB_q >> 1;
                    shS_q   <= (WIDTH-1)'({fa_s, shS_q} >> 1);
                    carry_q <= fa_co;
                    if (cnt_q == LAST) begin
                        S_q     <= {fa_s, shS_q};
                        COut_q  <= fa_co;
                        // carry_q is the carry into the MSB on this edge.
                        Ovf_q   <= carry_q ^ fa_co;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = (state_q == RUN);
    assign Done = (state_q == DONE);
    assign S    = S_q;
    assign COut = COut_q;
    assign Ovf  = Ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          t0;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        CIn = 1'b0;
    logic        Start8 = 1'b0, Start16 = 1'b0;
    logic [7:0]  A8 = '0, B8 = '0;
    logic [15:0] A16 = '0, B16 = '0;
    logic        Busy8, Done8, COut8, Ovf8;
    logic        Busy16, Done16, COut16, Ovf16;
    logic [7:0]  S8;
    logic [15:0] S16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done8_cnt = 0;
    int done16_cnt = 0;
    int busy8_run = 0;
    int busy16_run = 0;
    exp_t sb8[$];
    exp_t sb16[$];

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .Start(Start8), .A(A8), .B(B8), .CIn(CIn),
        .Busy(Busy8), .Done(Done8), .S(S8), .COut(COut8), .Ovf(Ovf8)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .Start(Start16), .A(A16), .B(B16), .CIn(CIn),
        .Busy(Busy16), .Done(Done16), .S(S16), .COut(COut16), .Ovf(Ovf16)
    );

    initial forever #5 Clk = ~Clk;
    initial forever begin @(posedge Clk); cyc++; end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input logic ci);
        exp_t e;
        logic [16:0] sum;
        e = '0;
        if (w == 8) begin
            sum  = {9'd0, a[7:0]} + {9'd0, b[7:0]} + {16'd0, ci};
            e.s  = {8'd0, sum[7:0]};
            e.co = sum[8];
            e.ov = (a[7] == b[7]) && (sum[7] != a[7]);
        end else begin
            sum  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            e.s  = sum[15:0];
            e.co = sum[16];
            e.ov = (a[15] == b[15]) && (sum[15] != a[15]);
        end
        return e;
    endfunction

    // Scoreboard monitors: compare on every Done, including result latency
    // and the number of Busy cycles that preceded it.
    initial forever begin
        exp_t e;
        @(negedge Clk);
        if (Rst) busy8_run = 0;
        else begin
            if (Done8) begin
                done8_cnt++;
                if (sb8.size() == 0) chk("unexpected_done8", 1, 0);
                else begin
                    e = sb8.pop_front();
                    chk("s8", {24'd0, S8}, {16'd0, e.s});
                    chk("cout8", {31'd0, COut8}, {31'd0, e.co});
                    chk("ovf8", {31'd0, Ovf8}, {31'd0, e.ov});
                    chk("lat8", cyc - e.t0, 9);
                    chk("busy8_len", busy8_run, 8);
                end
                busy8_run = 0;
            end
            if (Busy8) busy8_run++;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge Clk);
        if (Rst) busy16_run = 0;
        else begin
            if (Done16) begin
                done16_cnt++;
                if (sb16.size() == 0) chk("unexpected_done16", 1, 0);
                else begin
                    e = sb16.pop_front();
                    chk("s16", {16'd0, S16}, {16'd0, e.s});
                    chk("cout16", {31'd0, COut16}, {31'd0, e.co});
                    chk("ovf16", {31'd0, Ovf16}, {31'd0, e.ov});
                    chk("lat16", cyc - e.t0, 17);
                    chk("busy16_len", busy16_run, 16);
                end
                busy16_run = 0;
            end
            if (Busy16) busy16_run++;
        end
    end

    // Drive a one-cycle Start from a negedge; push the expectation only when
    // the DUT is expected to accept it.
    task automatic go(input int w, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input bit accept);
        exp_t e;
        e    = ref_add(w, a, b, ci);
        e.t0 = cyc;
        CIn  = ci;
        if (w == 8) begin
            A8 = a[7:0]; B8 = b[7:0]; Start8 = 1'b1;
            if (accept) sb8.push_back(e);
        end else begin
            A16 = a; B16 = b; Start16 = 1'b1;
            if (accept) sb16.push_back(e);
        end
        @(negedge Clk);
        Start8  = 1'b0;
        Start16 = 1'b0;
    endtask

    task automatic drain(input int w);
        for (int i = 0; i < 60; i++) begin
            if ((w == 8 ? sb8.size() : sb16.size()) == 0) break;
            @(negedge Clk);
        end
        chk("drain_timeout", (w == 8) ? sb8.size() : sb16.size(), 0);
    endtask

    task automatic chk_zero8(input string tag);
        chk({tag, "_busy"}, {31'd0, Busy8}, 0);
        chk({tag, "_done"}, {31'd0, Done8}, 0);
        chk({tag, "_s"}, {24'd0, S8}, 0);
        chk({tag, "_cout"}, {31'd0, COut8}, 0);
        chk({tag, "_ovf"}, {31'd0, Ovf8}, 0);
    endtask

    initial begin
        int d0;
        logic [15:0] ra, rb;
        bit seen;

        repeat (2) @(negedge Clk);
        chk_zero8("rst_init");
        Rst = 1'b0;
        @(negedge Clk);

        // 0x5A + 0x33 = 0x8D, signed overflow
        d0 = done8_cnt;
        go(8, 16'h5A, 16'h33, 1'b0, 1);
        drain(8);
        chk("done_once_5a33", done8_cnt - d0, 1);

        // asynchronous reset mid-cycle, no edge needed
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1 chk_zero8("rst_async");
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // 0xFF + 0x01, then back-to-back start from the DONE cycle
        go(8, 16'hFF, 16'h01, 1'b0, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Done8) begin seen = 1; break; end
        end
        chk("b2b_done_seen", {31'd0, seen}, 1);
        go(8, 16'hFF, 16'hFF, 1'b1, 1);
        drain(8);

        // Start during RUN must be ignored
        d0 = done8_cnt;
        go(8, 16'h10, 16'h20, 1'b0, 1);
        @(negedge Clk);
        go(8, 16'h01, 16'h01, 1'b0, 0);
        drain(8);
        repeat (12) @(negedge Clk);
        chk("ignored_start_done_cnt", done8_cnt - d0, 1);

        // reset in RUN aborts with no Done
        go(8, 16'h0F, 16'h01, 1'b0, 1);
        repeat (3) @(negedge Clk);
        #2 Rst = 1'b1;
        sb8.delete();
        d0 = done8_cnt;
        #1 chk_zero8("rst_run");
        @(negedge Clk);
        Rst = 1'b0;
        repeat (12) @(negedge Clk);
        chk("abort_no_done", done8_cnt - d0, 0);
        go(8, 16'h03, 16'h04, 1'b0, 1);
        drain(8);
        chk("after_abort_done", done8_cnt - d0, 1);

        // random sweeps
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            go(8, ra, rb, 1'($urandom_range(0, 1)), 1);
            drain(8);
        end
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            go(16, ra, rb, 1'($urandom_range(0, 1)), 1);
            drain(16);
        end
        chk("sweep16_done_cnt", done16_cnt, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
